// File: rtl/axi_lite_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave
//
// AXI4-Lite responder in front of a word-addressed on-chip SRAM. It serves one
// transaction at a time, and the read and write response latencies can be set
// by parameter. Reads take priority over writes when they arrive together and
// no write half is latched yet. A latched AW or W half blocks new reads until
// that write has finished.
//
// Parameters
//   ADDR_BASE    byte address of SRAM word 0
//   DEPTH_WORDS  SRAM depth in 32-bit words (power of 2)
//   RD_LATENCY   cycles from the AR handshake to rvalid (>=1)
//   WR_LATENCY   cycles from the later AW/W handshake to bvalid (>=1)
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   awaddr/awvalid/awready    write address channel
//   wdata/wstrb/wvalid/wready write data channel (wstrb bit i -> wdata[8i+7:8i])
//   bresp/bvalid/bready       write response (00 OKAY, 10 SLVERR)
//   araddr/arvalid/arready    read address channel
//   rdata/rresp/rvalid/rready read data channel (00 OKAY, 10 SLVERR)
// -----------------------------------------------------------------------------
module axi_lite_sram_slave #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          RD_LATENCY  = 1,
   parameter int          WR_LATENCY  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready
);

   localparam int IDX_W   = $clog2(DEPTH_WORDS);
   localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   // The counter only ever holds LATENCY-1, so clog2(LAT_MAX) bits are enough.
   localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RD_RESP = 3'd2,
      WR_WAIT = 3'd3,
      WR_RESP = 3'd4
   } state_t;

   // A 33-bit compare keeps the window check from wrapping near the top of
   // the 32-bit address space.
   function automatic logic addr_in_range(input logic [31:0] a);
      logic [32:0] lo;
      logic [32:0] hi;
      lo = {1'b0, ADDR_BASE};
      hi = lo + 33'(4 * DEPTH_WORDS);
      return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - ADDR_BASE;
      return IDX_W'(off >> 2);
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              aw_got_q, aw_got_d;
   logic              w_got_q, w_got_d;
   logic [31:0]       rd_addr_q, rd_addr_d;
   logic [31:0]       wr_addr_q, wr_addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [1:0]        bresp_q, bresp_d;

   logic              rd_fire;
   logic              wr_fire;
   logic              wr_ok;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic [31:0]       rd_word;

   assign rd_idx = word_idx(rd_addr_q);
   assign wr_idx = word_idx(wr_addr_q);
   assign wr_ok  = addr_in_range(wr_addr_q);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rresp_q   <= RESP_OKAY;
         bresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rresp_q   <= rresp_d;
         bresp_q   <= bresp_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rresp_d   = rresp_q;
      bresp_d   = bresp_q;
      rd_fire   = 1'b0;
      wr_fire   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (arvalid && arready) begin
               rd_addr_d = araddr;
               cnt_d     = CNT_W'(RD_LATENCY - 1);
               state_d   = RD_WAIT;
            end else begin
               if (awvalid && awready) begin
                  aw_got_d  = 1'b1;
                  wr_addr_d = awaddr;
               end
               if (wvalid && wready) begin
                  w_got_d = 1'b1;
                  wdata_d = wdata;
                  wstrb_d = wstrb;
               end
               // The same-cycle AW+W case lands here too, because the
               // updated flags are tested.
               if (aw_got_d && w_got_d) begin
                  cnt_d   = CNT_W'(WR_LATENCY - 1);
                  state_d = WR_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               rd_fire = 1'b1;
               rresp_d = addr_in_range(rd_addr_q) ? RESP_OKAY : RESP_SLVERR;
               state_d = RD_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RD_RESP: begin
            if (rready) begin
               state_d = IDLE;
            end
         end
         WR_WAIT: begin
            if (cnt_q == '0) begin
               wr_fire  = 1'b1;
               bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               state_d  = WR_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_RESP: begin
            if (bready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      // Readies are also held low while rst is asserted.
      if (!rst) begin
         arready = (state_q == IDLE) && !aw_got_q && !w_got_q;
         awready = (state_q == IDLE) && !aw_got_q && !arvalid;
         wready  = (state_q == IDLE) && !w_got_q  && !arvalid;
      end
      rvalid = (state_q == RD_RESP);
      bvalid = (state_q == WR_RESP);
   end

   assign rresp = rresp_q;
   assign bresp = bresp_q;
   // The RAM output register is not reset. rdata is forced to zero unless an
   // OKAY response is being presented, which covers both reset and SLVERR.
   assign rdata = ((state_q == RD_RESP) && (rresp_q == RESP_OKAY)) ? rd_word : 32'h0;

   // ------------------------------------------------------------------
   // SRAM: one byte-wide array per lane, so byte strobes map onto plain
   // per-lane write enables. Reads are registered. Both the write and the
   // read key off state_q, so an asynchronous reset in WR_WAIT suppresses
   // the commit.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] rd_byte_q;

         always_ff @(posedge clk) begin
            if (wr_fire && wr_ok && wstrb_q[gi]) begin
               mem[wr_idx] <= wdata_q[8*gi +: 8];
            end
            if (rd_fire) begin
               rd_byte_q <= mem[rd_idx];
            end
         end

         assign rd_word[8*gi +: 8] = rd_byte_q;
      end
   endgenerate

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_sram_slave
//
// Directed bench with two responder instances on one clock:
//   index 0: RD_LATENCY=1, WR_LATENCY=1
//   index 1: RD_LATENCY=4, WR_LATENCY=2
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_axi_lite_sram_slave;

   logic clk = 1'b0;
   logic rst;

   logic [1:0][31:0] awaddr, wdata, araddr, rdata;
   logic [1:0][3:0]  wstrb;
   logic [1:0][1:0]  bresp, rresp;
   logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]       arvalid, arready, rvalid, rready;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   axi_lite_sram_slave #(.RD_LATENCY(1), .WR_LATENCY(1)) u_dut0 (
      .clk(clk), .rst(rst),
      .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
      .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
      .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]),
      .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
      .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0])
   );

   axi_lite_sram_slave #(.RD_LATENCY(4), .WR_LATENCY(2)) u_dut1 (
      .clk(clk), .rst(rst),
      .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
      .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
      .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]),
      .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
      .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end
   endtask

   // Waits for bvalid; returns the number of cycles seen after the handshake
   // edge (capped at 50), then completes the B handshake.
   task automatic finish_write(input int p, input logic [1:0] exp_resp, input int exp_lat,
                               input string tag);
      int lat;
      lat = 0;
      #1;
      while (!bvalid[p] && lat < 50) begin
         @(negedge clk); #1; lat++;
      end
      check({tag, "_blat"}, lat, exp_lat);
      check({tag, "_bresp"}, bresp[p], exp_resp);
      $display("[%0t] dut%0d WRITE %s bresp=%0d lat=%0d", $time, p, tag, bresp[p], lat);
      bready[p] = 1'b1;
      @(negedge clk);
      bready[p] = 1'b0;
      #1;
      check({tag, "_bdone"}, bvalid[p], 1'b0);
   endtask

   task automatic axi_write(input int p, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp,
                            input int exp_lat, input string tag);
      int n;
      @(negedge clk);
      awaddr[p] = a; wdata[p] = d; wstrb[p] = s;
      awvalid[p] = 1'b1; wvalid[p] = 1'b1;
      #1;
      n = 0;
      while (!(awready[p] && wready[p]) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      @(negedge clk);
      awvalid[p] = 1'b0; wvalid[p] = 1'b0;
      finish_write(p, exp_resp, exp_lat, tag);
   endtask

   // Performs a read, holds rready low for 'hold' extra cycles while checking
   // that the response stays put, then completes the R handshake.
   task automatic axi_read(input int p, input logic [31:0] a, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int exp_lat, input int hold,
                           input string tag);
      int n;
      int lat;
      @(negedge clk);
      araddr[p] = a; arvalid[p] = 1'b1;
      #1;
      n = 0;
      while (!arready[p] && n < 50) begin
         @(negedge clk); #1; n++;
      end
      @(negedge clk);
      arvalid[p] = 1'b0;
      lat = 0;
      #1;
      while (!rvalid[p] && lat < 50) begin
         @(negedge clk); #1; lat++;
      end
      check({tag, "_rlat"}, lat, exp_lat);
      check({tag, "_rresp"}, rresp[p], exp_resp);
      check({tag, "_rdata"}, rdata[p], exp_data);
      $display("[%0t] dut%0d READ %s addr=0x%08h rdata=0x%08h rresp=%0d lat=%0d",
               $time, p, tag, a, rdata[p], rresp[p], lat);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         check({tag, "_hold_v"}, rvalid[p], 1'b1);
         check({tag, "_hold_d"}, rdata[p], exp_data);
         check({tag, "_hold_ar"}, arready[p], 1'b0);
      end
      rready[p] = 1'b1;
      @(negedge clk);
      rready[p] = 1'b0;
      #1;
      check({tag, "_rdone"}, rvalid[p], 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      logic seen;
      rst = 1'b1;
      awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
      awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;

      // 1: reset state, then readies after release
      repeat (3) @(negedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         check("rst_outputs", {arready[p], awready[p], wready[p], rvalid[p], bvalid[p],
                               rresp[p], bresp[p], rdata[p]}, 32'h0);
      end
      rst = 1'b0;
      #1;
      for (int p = 0; p < 2; p++) begin
         check("rel_readies", {arready[p], awready[p], wready[p]}, 3'b111);
      end

      // 2: write then read, latency 1
      axi_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 1, "t2w");
      axi_read (0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1, 0, "t2r");

      // 3: byte strobes, plus an all-zero strobe that must leave the word alone
      axi_write(0, 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 1, "t3w0");
      axi_write(0, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 1, "t3w1");
      axi_read (0, 32'h8000_0020, 32'h11BB_33DD, 2'b00, 1, 0, "t3r");
      axi_write(0, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 2'b00, 1, "t3w2");
      axi_read (0, 32'h8000_0020, 32'h11BB_33DD, 2'b00, 1, 0, "t3r2");

      // 4: W three cycles ahead of AW on the slower instance
      @(negedge clk);
      wdata[1] = 32'hCAFE_F00D; wstrb[1] = 4'hF; wvalid[1] = 1'b1;
      #1;
      check("t4_wrdy", wready[1], 1'b1);
      @(negedge clk);
      wvalid[1] = 1'b0;
      #1;
      check("t4_wdrop", wready[1], 1'b0);
      check("t4_arblk", arready[1], 1'b0);
      repeat (2) @(negedge clk);
      awaddr[1] = 32'h8000_0100; awvalid[1] = 1'b1;
      #1;
      check("t4_awrdy", awready[1], 1'b1);
      @(negedge clk);
      awvalid[1] = 1'b0;
      finish_write(1, 2'b00, 2, "t4w");
      axi_read(1, 32'h8000_0100, 32'hCAFE_F00D, 2'b00, 4, 0, "t4r");

      // 5: decode errors, window edge, read priority
      axi_write(0, 32'h8000_0000, 32'h0BAD_CAFE, 4'hF, 2'b00, 1, "t5w0");
      axi_write(0, 32'h8000_3FFC, 32'h5A5A_A5A5, 4'hF, 2'b00, 1, "t5wtop");
      axi_read (0, 32'h8000_3FFC, 32'h5A5A_A5A5, 2'b00, 1, 0, "t5rtop");
      axi_read (0, 32'h7FFF_FFFC, 32'h0, 2'b10, 1, 0, "t5rlo");
      axi_write(0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'b10, 1, "t5whi");
      axi_read (0, 32'h8000_0000, 32'h0BAD_CAFE, 2'b00, 1, 0, "t5rw0");

      @(negedge clk);
      araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1;
      awaddr[0] = 32'h8000_0010; awvalid[0] = 1'b1;
      wdata[0]  = 32'h1234_5678; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
      #1;
      check("t5_pri", {arready[0], awready[0], wready[0]}, 3'b100);
      @(negedge clk);
      arvalid[0] = 1'b0;
      @(negedge clk);
      #1;
      check("t5_pri_rv", rvalid[0], 1'b1);
      check("t5_pri_rd", rdata[0], 32'hDEAD_BEEF);
      $display("[%0t] dut0 READ t5pri rdata=0x%08h", $time, rdata[0]);
      rready[0] = 1'b1;
      @(negedge clk);
      rready[0] = 1'b0;
      #1;
      check("t5_pri_wrdy", {awready[0], wready[0]}, 2'b11);
      @(negedge clk);
      awvalid[0] = 1'b0; wvalid[0] = 1'b0;
      finish_write(0, 2'b00, 1, "t5priw");

      // 6: backpressure on R, then reset inside WR_WAIT
      axi_read(0, 32'h8000_0010, 32'h1234_5678, 2'b00, 1, 10, "t6r");

      @(negedge clk);
      awaddr[1] = 32'h8000_0100; wdata[1] = 32'hFFFF_0000; wstrb[1] = 4'hF;
      awvalid[1] = 1'b1; wvalid[1] = 1'b1;
      #1;
      check("t6_wrdy", {awready[1], wready[1]}, 2'b11);
      @(negedge clk);
      awvalid[1] = 1'b0; wvalid[1] = 1'b0;
      rst = 1'b1;
      #1;
      check("t6_rst_b", bvalid[1], 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         seen = seen | bvalid[1];
      end
      check("t6_no_bvalid", seen, 1'b0);
      $display("[%0t] dut1 WRITE t6abort (reset in WR_WAIT)", $time);
      axi_read(1, 32'h8000_0100, 32'hCAFE_F00D, 2'b00, 4, 0, "t6keep");

      lat = n_total;
      $display("test done: total=%0d bad=%0d", lat, n_bad);
      $finish;
   end

endmodule
